// File: rtl/fir_prog_ffe.sv
// Pipelined FIR feed-forward equaliser with a shadow/active coefficient bank pair.
// The bank swap lands only on an enabled edge, and the output is rounded and saturated.
module fir_prog_ffe #(
  parameter int unsigned FIR_LEN   = 21,
  parameter int unsigned NB_COEFF  = 8,
  parameter int unsigned NBF_COEFF = 7,
  parameter int unsigned NB_IN     = 8,
  parameter int unsigned NBF_IN    = 7,
  parameter int unsigned NB_OUT    = 8,
  parameter int unsigned NBF_OUT   = 6,
  parameter int unsigned NB_ADDR   = 5
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic                i_valid,
  input  logic [NB_IN-1:0]    i_data,
  input  logic                i_coeff_wr,
  input  logic [NB_ADDR-1:0]  i_coeff_addr,
  input  logic [NB_COEFF-1:0] i_coeff_data,
  input  logic                i_coeff_commit,
  input  logic                i_round_mode,
  output logic [NB_OUT-1:0]   o_data,
  output logic                o_valid,
  output logic                o_sat,
  output logic                o_commit_pending,
  output logic                o_commit_done
);

  localparam int unsigned NB_PROD = NB_IN + NB_COEFF;
  localparam int unsigned NB_ACC  = NB_PROD + $clog2(FIR_LEN);
  localparam int unsigned NBF_ACC = NBF_IN + NBF_COEFF;
  localparam int unsigned SH      = NBF_ACC - NBF_OUT;
  localparam int unsigned SH_M1   = (SH > 0) ? SH - 1 : 0;
  localparam int unsigned NB_RND  = NB_ACC + 1;

  localparam logic signed [NB_RND-1:0] HALF    = (SH > 0) ? (NB_RND'(1) << SH_M1) : '0;
  localparam logic signed [NB_RND-1:0] OUT_MAX = (NB_RND'(1) << (NB_OUT - 1)) - NB_RND'(1);
  localparam logic signed [NB_RND-1:0] OUT_MIN = -OUT_MAX - NB_RND'(1);

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } state_t;

  logic signed [NB_IN-1:0]    x_q      [FIR_LEN];
  logic signed [NB_COEFF-1:0] shadow_q [FIR_LEN];
  logic signed [NB_COEFF-1:0] active_q [FIR_LEN];
  logic signed [NB_PROD-1:0]  prod_q   [FIR_LEN];
  logic signed [NB_ACC-1:0]   acc_q, acc_d;
  logic signed [NB_RND-1:0]   rnd_c, shf_c;
  logic [NB_OUT-1:0]          q_c, data_q;
  logic                       sat_c, sat_q;
  logic [2:0]                 vld_q;
  logic                       valid_q;
  state_t                     state_q, state_d;
  logic                       done_q, done_d;
  logic                       copy_c;

  // Commit FSM: request is latched on any edge, the copy waits for an enabled edge.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    copy_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_coeff_commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (i_en) begin
          copy_c  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Shadow bank writes ignore the clock enable; out-of-range addresses match no tap.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < FIR_LEN; k++) shadow_q[k] <= '0;
    end else if (i_coeff_wr) begin
      for (int k = 0; k < FIR_LEN; k++) begin
        if (i_coeff_addr == NB_ADDR'(k)) shadow_q[k] <= i_coeff_data;
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < FIR_LEN; k++) active_q[k] <= '0;
    end else if (copy_c) begin
      for (int k = 0; k < FIR_LEN; k++) active_q[k] <= shadow_q[k];
    end
  end

  // Adder tree over full-precision products; NB_ACC leaves room for FIR_LEN terms.
  always_comb begin
    acc_d = '0;
    for (int k = 0; k < FIR_LEN; k++) acc_d = acc_d + NB_ACC'(prod_q[k]);
  end

  // Optional half-up offset, floor shift, then clamp to the output range.
  always_comb begin
    rnd_c = NB_RND'(acc_q);
    if (i_round_mode) rnd_c = rnd_c + HALF;
    shf_c = rnd_c >>> SH;
    sat_c = 1'b0;
    q_c   = shf_c[NB_OUT-1:0];
    if (shf_c > OUT_MAX) begin
      q_c   = OUT_MAX[NB_OUT-1:0];
      sat_c = 1'b1;
    end else if (shf_c < OUT_MIN) begin
      q_c   = OUT_MIN[NB_OUT-1:0];
      sat_c = 1'b1;
    end
  end

  // Datapath: delay line, products, sum, quantised output, all gated by i_en.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < FIR_LEN; k++) begin
        x_q[k]    <= '0;
        prod_q[k] <= '0;
      end
      acc_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      vld_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_en) begin
      x_q[0] <= i_valid ? i_data : '0;
      for (int k = 1; k < FIR_LEN; k++) x_q[k] <= x_q[k-1];
      for (int k = 0; k < FIR_LEN; k++) begin
        prod_q[k] <= NB_PROD'(active_q[k]) * NB_PROD'(x_q[k]);
      end
      acc_q   <= acc_d;
      data_q  <= q_c;
      sat_q   <= sat_c;
      vld_q   <= {vld_q[1:0], i_valid};
      valid_q <= vld_q[2];
    end
  end

  assign o_data           = data_q;
  assign o_valid          = valid_q;
  assign o_sat            = sat_q;
  assign o_commit_pending = (state_q == ST_PENDING);
  assign o_commit_done    = done_q;

endmodule

// File: tb/tb_fir_prog_ffe.sv
// Directed bench for fir_prog_ffe: hand-computed vector table, commit and reset
// sequences, and a cycle-by-cycle behavioural model checked on every step.
module tb_fir_prog_ffe;

  localparam int FIR_LEN = 21;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_en, i_valid, i_coeff_wr, i_coeff_commit, i_round_mode;
  logic [7:0] i_data, i_coeff_data;
  logic [4:0] i_coeff_addr;
  logic [7:0] o_data;
  logic       o_valid, o_sat, o_commit_pending, o_commit_done;

  always #5 clk = ~clk;

  fir_prog_ffe dut (
    .clk(clk), .i_reset(i_reset), .i_en(i_en), .i_valid(i_valid), .i_data(i_data),
    .i_coeff_wr(i_coeff_wr), .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data),
    .i_coeff_commit(i_coeff_commit), .i_round_mode(i_round_mode),
    .o_data(o_data), .o_valid(o_valid), .o_sat(o_sat),
    .o_commit_pending(o_commit_pending), .o_commit_done(o_commit_done)
  );

  int errors = 0;
  int checks = 0;
  bit cur_rm = 1'b0;
  int rc = 0;

  // Behavioural model state
  int     ma [FIR_LEN];
  int     ms [FIR_LEN];
  int     mx [FIR_LEN];
  bit     mvx, vb, va, ev, es, mpend, mdone;
  longint sb, sa;
  int     ed;

  typedef struct {
    bit         is_const;
    int         tap;
    logic [7:0] coeff;
    logic [7:0] x;
    bit         rm;
    logic [7:0] exp_d;
    bit         exp_sat;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int s8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic void quant(input longint s, input bit rm, output int y, output bit sat);
    longint t, q;
    t = s + (rm ? 64'sd128 : 64'sd0);
    if (t >= 0) q = t / 256;
    else        q = -((-t + 255) / 256);
    sat = 1'b0;
    if (q > 127) begin q = 127; sat = 1'b1; end
    else if (q < -128) begin q = -128; sat = 1'b1; end
    y = int'(q) & 32'hFF;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < FIR_LEN; k++) begin ma[k] = 0; ms[k] = 0; mx[k] = 0; end
    mvx = 0; vb = 0; va = 0; ev = 0; es = 0; mpend = 0; mdone = 0;
    sb = 0; sa = 0; ed = 0;
  endtask

  task automatic model_edge();
    longint ns;
    bit     cp;
    if (i_en) begin
      ns = 0;
      for (int k = 0; k < FIR_LEN; k++) ns += longint'(ma[k]) * mx[k];
      quant(sa, i_round_mode, ed, es);
      ev = va;
      sa = sb; va = vb;
      sb = ns; vb = mvx;
      for (int k = FIR_LEN - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = i_valid ? s8(i_data) : 0;
      mvx = i_valid;
    end
    cp = mpend && i_en;
    mdone = cp;
    if (cp) begin
      ma = ms;
      mpend = 0;
    end else if (i_coeff_commit) begin
      mpend = 1;
    end
    if (i_coeff_wr && int'(i_coeff_addr) < FIR_LEN) ms[i_coeff_addr] = s8(i_coeff_data);
  endtask

  task automatic step(input bit en, input bit vld, input logic [7:0] d,
                      input bit wr = 1'b0, input logic [4:0] addr = '0,
                      input logic [7:0] cd = '0, input bit cm = 1'b0);
    i_en = en; i_valid = vld; i_data = d;
    i_coeff_wr = wr; i_coeff_addr = addr; i_coeff_data = cd;
    i_coeff_commit = cm; i_round_mode = cur_rm;
    @(posedge clk);
    model_edge();
    #1;
    chk("m_data", int'(o_data), ed);
    chk("m_valid", int'(o_valid), int'(ev));
    chk("m_sat", int'(o_sat), int'(es));
    chk("m_pending", int'(o_commit_pending), int'(mpend));
    chk("m_done", int'(o_commit_done), int'(mdone));
  endtask

  // Ramp stream; the ramp only advances on enabled cycles.
  task automatic rstep(input bit en, input bit wr = 1'b0, input logic [4:0] addr = '0,
                       input logic [7:0] cd = '0, input bit cm = 1'b0);
    step(en, 1'b1, 8'(rc * 7), wr, addr, cd, cm);
    if (en) rc++;
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    i_en = 0; i_valid = 0; i_data = 0; i_coeff_wr = 0; i_coeff_addr = 0;
    i_coeff_data = 0; i_coeff_commit = 0; i_round_mode = 0;
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int done_cnt;
    tbl[0] = '{1'b0, 0,  8'h40, 8'h7F, 1'b0, 8'h1F, 1'b0};
    tbl[1] = '{1'b0, 0,  8'h40, 8'h7F, 1'b1, 8'h20, 1'b0};
    tbl[2] = '{1'b0, 5,  8'h40, 8'h40, 1'b0, 8'h10, 1'b0};
    tbl[3] = '{1'b0, 20, 8'h7F, 8'h7F, 1'b0, 8'h3F, 1'b0};
    tbl[4] = '{1'b0, 0,  8'h01, 8'h80, 1'b0, 8'hFF, 1'b0};
    tbl[5] = '{1'b0, 0,  8'h01, 8'h80, 1'b1, 8'h00, 1'b0};
    tbl[6] = '{1'b1, 0,  8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b1};
    tbl[7] = '{1'b1, 0,  8'h7F, 8'h80, 1'b0, 8'h80, 1'b1};
    tbl[8] = '{1'b1, 0,  8'h7F, 8'h00, 1'b0, 8'h00, 1'b0};

    // Reset state
    do_reset();
    chk("rst_data", int'(o_data), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_sat", int'(o_sat), 0);
    chk("rst_pending", int'(o_commit_pending), 0);
    chk("rst_done", int'(o_commit_done), 0);

    // Vector table: program bank, commit, flush, then impulse or constant stream
    for (int r = 0; r < 9; r++) begin
      cur_rm = tbl[r].rm;
      for (int k = 0; k < FIR_LEN; k++)
        step(1'b1, 1'b1, 8'h00, 1'b1, 5'(k),
             (tbl[r].is_const || k == tbl[r].tap) ? tbl[r].coeff : 8'h00);
      step(1'b1, 1'b1, 8'h00, 1'b0, '0, '0, 1'b1);
      step(1'b1, 1'b1, 8'h00);
      repeat (FIR_LEN + 4) step(1'b1, 1'b1, 8'h00);
      if (!tbl[r].is_const) begin
        step(1'b1, 1'b1, tbl[r].x);
        for (int j = 1; j <= tbl[r].tap + 3; j++) begin
          step(1'b1, 1'b1, 8'h00);
          if (j == tbl[r].tap + 2) chk($sformatf("v%0d_early", r), int'(o_data), 0);
          if (j == tbl[r].tap + 3) begin
            chk($sformatf("v%0d_data", r), int'(o_data), int'(tbl[r].exp_d));
            chk($sformatf("v%0d_valid", r), int'(o_valid), 1);
            chk($sformatf("v%0d_sat", r), int'(o_sat), int'(tbl[r].exp_sat));
          end
        end
      end else begin
        repeat (FIR_LEN + 4) step(1'b1, 1'b1, tbl[r].x);
        chk($sformatf("v%0d_data", r), int'(o_data), int'(tbl[r].exp_d));
        chk($sformatf("v%0d_valid", r), int'(o_valid), 1);
        chk($sformatf("v%0d_sat", r), int'(o_sat), int'(tbl[r].exp_sat));
      end
    end

    // Commit boundary with a ramp: bank A, then bank B committed with i_en low
    do_reset();
    cur_rm = 1'b0;
    rstep(1'b1, 1'b1, 5'd0, 8'h40);
    rstep(1'b1, 1'b1, 5'd1, 8'h20);
    rstep(1'b1, 1'b1, 5'd2, 8'hF0);
    rstep(1'b1, 1'b0, '0, '0, 1'b1);
    rstep(1'b1);
    repeat (6) rstep(1'b1);
    rstep(1'b1, 1'b1, 5'd0, 8'h10);
    rstep(1'b1, 1'b1, 5'd1, 8'h7F);
    rstep(1'b0, 1'b1, 5'd2, 8'h30, 1'b1);
    chk("cb_pend_req", int'(o_commit_pending), 1);
    rstep(1'b0);
    rstep(1'b0);
    chk("cb_pend_hold", int'(o_commit_pending), 1);
    chk("cb_no_done", int'(o_commit_done), 0);
    rstep(1'b1);
    chk("cb_done", int'(o_commit_done), 1);
    chk("cb_pend_clr", int'(o_commit_pending), 0);
    rstep(1'b1, 1'b0, '0, '0, 1'b1);
    chk("cb_done_once", int'(o_commit_done), 0);
    chk("cb_pend_again", int'(o_commit_pending), 1);
    rstep(1'b1);
    rstep(1'b0, 1'b0, '0, '0, 1'b1);
    rstep(1'b0, 1'b0, '0, '0, 1'b1);
    done_cnt = 0;
    repeat (4) begin
      rstep(1'b1);
      done_cnt += int'(o_commit_done);
    end
    chk("cb_merged_cnt", done_cnt, 1);
    repeat (25) rstep(1'b1);

    // Random enable/valid gaps, writes (including out-of-range) and commits
    do_reset();
    repeat (400) begin
      cur_rm = 1'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 8'($urandom),
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), 8'($urandom),
           $urandom_range(0, 15) == 0);
    end

    // Out-of-range writes leave the active bank zero
    do_reset();
    cur_rm = 1'b0;
    for (int a = FIR_LEN; a < 32; a++) step(1'b1, 1'b1, 8'h00, 1'b1, 5'(a), 8'h7F);
    step(1'b1, 1'b1, 8'h00, 1'b0, '0, '0, 1'b1);
    step(1'b1, 1'b1, 8'h00);
    repeat (FIR_LEN + 4) step(1'b1, 1'b1, 8'h7F);
    chk("oor_data", int'(o_data), 0);
    chk("oor_sat", int'(o_sat), 0);
    chk("oor_valid", int'(o_valid), 1);

    // Reset during a pending commit with a full pipeline
    do_reset();
    step(1'b1, 1'b1, 8'h00, 1'b1, 5'd0, 8'h40);
    step(1'b1, 1'b1, 8'h00, 1'b0, '0, '0, 1'b1);
    step(1'b1, 1'b1, 8'h00);
    repeat (8) step(1'b1, 1'b1, 8'h7F);
    step(1'b1, 1'b1, 8'h00, 1'b1, 5'd1, 8'h40);
    step(1'b0, 1'b1, 8'h7F, 1'b0, '0, '0, 1'b1);
    chk("mr_pend_before", int'(o_commit_pending), 1);
    chk("mr_valid_before", int'(o_valid), 1);
    #2;
    i_reset = 1'b0;
    #1;
    chk("mr_data", int'(o_data), 0);
    chk("mr_valid", int'(o_valid), 0);
    chk("mr_sat", int'(o_sat), 0);
    chk("mr_pending", int'(o_commit_pending), 0);
    chk("mr_done", int'(o_commit_done), 0);
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    model_reset();
    done_cnt = 0;
    step(1'b1, 1'b1, 8'h7F);
    for (int j = 1; j <= 4; j++) begin
      step(1'b1, 1'b0, 8'h00);
      done_cnt += int'(o_commit_done);
      if (j == 2) chk("mr_lat_early", int'(o_valid), 0);
      if (j == 3) begin
        chk("mr_lat_valid", int'(o_valid), 1);
        chk("mr_lat_data", int'(o_data), 0);
      end
    end
    chk("mr_no_done", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_prog_ffe.md
Name: fir_prog_ffe

Overview:
Parametrised, pipelined FIR equaliser (FFE) with run-time programmable coefficients.
- Coefficients are written into a shadow bank through a simple write port.
- The shadow bank is copied into the active bank by a commit handshake that lands only on a sample boundary.
- Output has selectable truncate/round quantisation, saturation and a saturation flag.
- Sits in the receiver datapath between the slicer-input quantiser and the decision/adaptation logic; it is the successor to the fixed-coefficient FFE.

Parameters:
FIR_LEN, 21, number of taps (>=2)
NB_COEFF, 8, coefficient width, signed
NBF_COEFF, 7, coefficient fractional bits
NB_IN, 8, input sample width, signed
NBF_IN, 7, input fractional bits
NB_OUT, 8, output width, signed
NBF_OUT, 6, output fractional bits; must satisfy NBF_OUT <= NBF_IN+NBF_COEFF
NB_ADDR, 5, coefficient address width; must satisfy 2^NB_ADDR >= FIR_LEN

Ports:
clk  input  1  clock
i_reset  input  1  reset, asynchronous, active-low
i_en  input  1  clock enable; the datapath and commit advance only when 1
i_valid  input  1  i_data qualifier
i_data  input  NB_IN  input sample S(NB_IN,NBF_IN)
i_coeff_wr  input  1  shadow-bank write strobe
i_coeff_addr  input  NB_ADDR  tap index; 0 = newest sample
i_coeff_data  input  NB_COEFF  coefficient S(NB_COEFF,NBF_COEFF)
i_coeff_commit  input  1  request shadow->active copy
i_round_mode  input  1  0 = truncate (floor), 1 = round half-up
o_data  output  NB_OUT  filtered sample S(NB_OUT,NBF_OUT)
o_valid  output  1  o_data qualifier
o_sat  output  1  high with the o_data word that was saturated
o_commit_pending  output  1  commit accepted, not yet applied
o_commit_done  output  1  one-cycle pulse after the active bank is updated

Behaviour:
Reset:
- Delay line, both coefficient banks, all pipeline registers and the valid pipe clear to 0.
- o_data=0, o_valid=0, o_sat=0, o_commit_pending=0, o_commit_done=0.
- Commit FSM returns to IDLE.
- Reset mid-stream discards everything in flight and any pending commit.

Delay line:
- On an edge with i_en=1: x[0] <= (i_valid ? i_data : 0), x[k] <= x[k-1].
- On i_en=0 everything holds, including o_valid.

Pipeline (edges counted with i_en=1 only):
- Capture edge n: x[0] loaded.
- Edge n+1: products p[k] = a[k]*x[k] registered, width NB_IN+NB_COEFF, full precision.
- Edge n+2: sum registered, width NB_ACC = NB_IN+NB_COEFF+ceil(log2(FIR_LEN)), NBF_ACC = NBF_IN+NBF_COEFF, no overflow possible.
- Edge n+3: quantised output registered.
- Latency is 3 enabled edges after capture.
- o_valid is i_valid delayed through the same 4 stages; invalid samples propagate as zeros with o_valid=0.

Quantisation:
- SH = NBF_ACC-NBF_OUT.
- Mode 1 adds 2^(SH-1) before the arithmetic right shift by SH; mode 0 shifts only (floor). With SH=0 the mode is ignored.
- i_round_mode is sampled at edge n+3.

Saturation:
- Result above 2^(NB_OUT-1)-1 -> 0111..1; below -2^(NB_OUT-1) -> 1000..0.
- o_sat=1 for that word. No wrap-around ever.

Coefficient write:
- When i_coeff_wr=1 the shadow bank at i_coeff_addr is written on the edge, independent of i_en.
- Addresses >= FIR_LEN are ignored.
- Writes never touch the active bank.

Commit FSM:
- IDLE --i_coeff_commit--> PENDING, registered on the edge; o_commit_pending=1.
- PENDING --first later edge with i_en=1--> active <= shadow, o_commit_done=1 for one cycle, back to IDLE.
- The copy never occurs on the request edge, so a write in the same cycle as the commit is included.
- Writes made while PENDING, before the copy edge, are included.
- A commit asserted while PENDING is merged (no second copy).
- A commit asserted in the done cycle starts a new PENDING.
- The product stage at the copy edge still uses the old active bank; products from the next enabled edge use the new bank. No sample ever mixes the two banks.

Test Plan:
- Impulse, truncate: write a[0]=0x40, commit; drive x=0x7F once, then zeros -> three enabled edges after capture, o_data=0x1F with o_valid=1; mode 1 gives 0x20; all other outputs 0.
- Tap ordering: a[k]=0x40 only at k=5; impulse x=0x40 -> o_data=0x10 exactly 5 samples later than the a[0] case.
- Saturation: all a[k]=0x7F; constant x=0x7F -> o_data=0x7F, o_sat=1; constant x=0x80 -> o_data=0x80, o_sat=1; x=0 -> o_data=0, o_sat=0.
- Commit boundary: stream a ramp under bank A, write bank B plus commit in the same cycle with i_en low for 3 cycles -> o_commit_pending held; copy on the first i_en=1 edge; o_commit_done pulses once; outputs match the A/B golden model switching on the correct sample; a second commit while PENDING gives a single done pulse.
- Gaps/enable: toggle i_valid and i_en randomly against a bit-accurate model -> o_data/o_valid/o_sat match every cycle; out-of-range address writes have no effect.
- Reset mid-stream: assert i_reset during a PENDING commit with a full pipeline -> all outputs 0 immediately; after release, no commit_done, active bank all zeros, first output appears at the specified latency.
